tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_pkg.sv | 14 +
 rtl/btn_edge.sv | 23 ++
 rtl/tick_gen.sv | 128 ++++++++++++
 tb/tb_tick_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared types and default timing constants for the seconds tick generator.
package tick_pkg;

  typedef enum logic [1:0] {
    StStop = 2'd0,
    StRun  = 2'd1,
    StSet  = 2'd2
  } tick_state_t;

  localparam int unsigned DefClkHz      = 50_000_000;
  localparam int unsigned DefHoldCycles = 25_000_000;
  localparam int unsigned DefRepeatDiv  = 6_250_000;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already synchronised, debounced level input.
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;

  always_comb d_d = d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/tick_gen.sv
// One-second tick generator with STOP/RUN/SET modes and a manual advance button.
// Define TICK_GEN_AUTOREPEAT_EN to add hold-to-repeat on the advance button.
module tick_gen
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DefClkHz,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned REPEAT_DIV  = DefRepeatDiv
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic set,
  input  logic adv_btn,
  output logic inc,
  output logic running
);

  localparam int unsigned PresW = $clog2(CLK_HZ);
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_HZ - 1);

  tick_state_t      state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             inc_q, inc_d;
  logic             running_q, running_d;
  logic             adv_rise, edge_pulse, rpt_fire, run_tick;

  btn_edge u_btn_edge (
    .clk    (clk),
    .resetn (resetn),
    .d      (adv_btn),
    .rise   (adv_rise)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop: begin
        if (set)      state_d = StSet;
        else if (run) state_d = StRun;
      end
      StRun: begin
        if (set)       state_d = StSet;
        else if (!run) state_d = StStop;
      end
      StSet: begin
        if (!set) state_d = run ? StRun : StStop;
      end
      default: state_d = StStop;
    endcase
  end

  // The RUN tick is decided on state_q alone, so a set arriving on the wrap still ticks.
  always_comb begin
    presc_d  = presc_q;
    run_tick = 1'b0;
    if (state_q == StRun) begin
      run_tick = (presc_q == PresMax);
      presc_d  = run_tick ? '0 : presc_q + PresW'(1);
    end else if (state_q == StSet) begin
      presc_d = '0;
    end
  end

  // An edge seen in the cycle SET is being left is dropped.
  assign edge_pulse = (state_q == StSet) && set && adv_rise;

`ifdef TICK_GEN_AUTOREPEAT_EN
  localparam int unsigned RptMax = (HOLD_CYCLES > REPEAT_DIV) ? HOLD_CYCLES : REPEAT_DIV;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            holding;

  // Zero means disarmed; a held press counts down and fires on reaching one.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    holding   = (state_q == StSet) && set && adv_btn;
    if (!holding) begin
      rpt_cnt_d = '0;
    end else if (adv_rise) begin
      rpt_cnt_d = RptW'(HOLD_CYCLES - 1);
    end else if (rpt_cnt_q == RptW'(1)) begin
      rpt_fire  = 1'b1;
      rpt_cnt_d = RptW'(REPEAT_DIV);
    end else if (rpt_cnt_q != '0) begin
      rpt_cnt_d = rpt_cnt_q - RptW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;

  logic unused_rpt_params;
  assign unused_rpt_params = ^{HOLD_CYCLES, REPEAT_DIV};
`endif

  always_comb begin
    inc_d     = (run_tick | edge_pulse | rpt_fire) & ~inc_q;
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StStop;
      presc_q   <= '0;
      inc_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      inc_q     <= inc_d;
      running_q <= running_d;
    end
  end

  assign inc     = inc_q;
  assign running = running_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: expected inc cycles are queued, a monitor matches pulses.
module tb_tick_gen;

  logic clk, resetn, run, set, adv_btn;
  logic inc, running;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];
  logic prev_inc = 1'b0;

`ifdef TICK_GEN_AUTOREPEAT_EN
  localparam bit AutoRpt = 1'b1;
`else
  localparam bit AutoRpt = 1'b0;
`endif

  tick_gen #(
    .CLK_HZ      (4),
    .HOLD_CYCLES (6),
    .REPEAT_DIV  (2)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .set     (set),
    .adv_btn (adv_btn),
    .inc     (inc),
    .running (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every inc pulse must match the head of the expected queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_inc: expected pulse at cycle %0d, still absent at cycle %0d",
               exp_q[0], cyc);
      exp_q.delete(0);
    end
    if (inc) begin
      n_tests++;
      if (exp_q.size() == 0 || exp_q[0] != cyc) begin
        n_fail++;
        $display("FAIL inc_timing: pulse at cycle %0d, next expected %0d", cyc,
                 (exp_q.size() > 0) ? exp_q[0] : -1);
      end else begin
        exp_q.delete(0);
      end
      if (prev_inc) begin
        n_fail++;
        $display("FAIL inc_width: inc high at cycles %0d and %0d, required single cycle",
                 cyc - 1, cyc);
      end
    end
    prev_inc = inc;
  end

  task automatic chk(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    adv_btn = 1'b1;
    exp_q.push_back(cyc + 1);
    cycles(hi);
    adv_btn = 1'b0;
    cycles(lo);
  endtask

  int t;

  initial begin
    resetn  = 1'b0;
    run     = 1'b0;
    set     = 1'b0;
    adv_btn = 1'b0;
    cycles(3);
    chk("reset_inc", inc, 1'b0);
    chk("reset_running", running, 1'b0);

    // Free-running ticks every 4 cycles from RUN entry.
    resetn = 1'b1;
    run    = 1'b1;
    t      = cyc;
    chk("stop_after_release", running, 1'b0);
    for (int k = 1; k <= 5; k++) exp_q.push_back(t + 1 + 4 * k);
    cycles(1);
    chk("run_entry_running", running, 1'b1);
    cycles(20);

    // Pause with the prescaler at 2, resume 2 cycles short of a tick.
    cycles(1);
    run = 1'b0;
    cycles(1);
    chk("pause_running", running, 1'b0);
    cycles(4);
    run = 1'b1;
    exp_q.push_back(cyc + 3);
    cycles(1);
    chk("resume_running", running, 1'b1);
    cycles(3);

    // SET mode: three manual advances, no periodic ticks.
    set = 1'b1;
    cycles(1);
    chk("set_running", running, 1'b0);
    cycles(1);
    press(2, 2);
    press(2, 2);
    press(2, 2);

    // Leave SET with an edge in the exit cycle: no pulse, then a full second.
    set     = 1'b0;
    adv_btn = 1'b1;
    exp_q.push_back(cyc + 5);
    exp_q.push_back(cyc + 9);
    cycles(1);
    chk("exit_set_running", running, 1'b1);
    cycles(9);

    // Long hold in SET.
    set     = 1'b1;
    adv_btn = 1'b0;
    cycles(2);
    adv_btn = 1'b1;
    t       = cyc;
    exp_q.push_back(t + 1);
    if (AutoRpt) begin
      exp_q.push_back(t + 6);
      exp_q.push_back(t + 8);
      exp_q.push_back(t + 10);
      exp_q.push_back(t + 12);
    end
    cycles(12);
    adv_btn = 1'b0;
    cycles(3);

    // set rises on the wrap cycle: final tick still issued.
    set = 1'b0;
    exp_q.push_back(cyc + 5);
    cycles(4);
    set = 1'b1;
    cycles(1);
    chk("wrap_set_running", running, 1'b0);
    cycles(10);

    // Asynchronous reset mid-second.
    set = 1'b0;
    cycles(3);
    chk("pre_reset_running", running, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_inc", inc, 1'b0);
    chk("async_reset_running", running, 1'b0);
    cycles(3);
    resetn = 1'b1;
    chk("post_reset_stop", running, 1'b0);
    exp_q.push_back(cyc + 5);
    cycles(6);

    // Asynchronous reset mid-repeat.
    set = 1'b1;
    cycles(2);
    adv_btn = 1'b1;
    exp_q.push_back(cyc + 1);
    cycles(6);
    chk("mid_repeat_inc", inc, AutoRpt);
    #2 resetn = 1'b0;
    #1;
    chk("repeat_reset_inc", inc, 1'b0);
    chk("repeat_reset_running", running, 1'b0);
    adv_btn = 1'b0;
    set     = 1'b0;
    run     = 1'b0;
    cycles(2);
    resetn = 1'b1;
    cycles(6);
    chk("final_stop_running", running, 1'b0);

    while (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_inc: expected pulse at cycle %0d never seen", exp_q[0]);
      exp_q.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
